// File: rtl/rlo_logic_unit.sv
// rlo_logic_unit: bit-logic unit feeding the RLO register's logic-unit-result input.
// Combines RLO with a single-bit operand (A/AN/O/ON/X/XN/NOT) and supports
// parenthesised nesting through a small stack of {RLO, FC, type} entries.
// Optional feature macro: RLO_LU_FC_EN
//   defined   -> first-check (FC) load semantics
//   undefined -> FC forced to 1: every logic op and every pop combines with RLO
module rlo_logic_unit #(
    parameter int unsigned STACK_DEPTH = 7,
    parameter int unsigned DEPTH_W     = 3
) (
    input  logic               CLK,
    input  logic               CPU_Reset,
    input  logic               LU_EN,
    input  logic [3:0]         LU_OPCode,
    input  logic               LU_Operand,
    input  logic               RLO,
    output logic               LU_Resoult,
    output logic               LU_Valid,
    output logic [DEPTH_W-1:0] LU_Depth,
    output logic               LU_FC,
    output logic               LU_Overflow,
    output logic               LU_Underflow
);

    localparam logic [DEPTH_W-1:0] MAX_DEPTH = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] ONE_DEPTH = DEPTH_W'(1);

    // Opcode encodings
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_A    = 4'b0001;
    localparam logic [3:0] OP_AN   = 4'b0010;
    localparam logic [3:0] OP_O    = 4'b0011;
    localparam logic [3:0] OP_ON   = 4'b0100;
    localparam logic [3:0] OP_X    = 4'b0101;
    localparam logic [3:0] OP_XN   = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_APSH = 4'b1000;
    localparam logic [3:0] OP_OPSH = 4'b1001;
    localparam logic [3:0] OP_XPSH = 4'b1010;
    localparam logic [3:0] OP_POP  = 4'b1011;
    localparam logic [3:0] OP_CLR  = 4'b1100;

    // Stacked combine type, taken from the low two bits of the push opcode
    localparam logic [1:0] TYP_AND = 2'b00;
    localparam logic [1:0] TYP_OR  = 2'b01;
    localparam logic [1:0] TYP_XOR = 2'b10;

    // Architectural state
    logic               res_q,   res_d;
    logic               valid_q, valid_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               fc_q,    fc_d;
    logic               ovf_q,   ovf_d;
    logic               unf_q,   unf_d;

    // Nesting stack (contents need no reset; depth qualifies them)
    logic               stk_rlo [STACK_DEPTH];
    logic               stk_fc  [STACK_DEPTH];
    logic [1:0]         stk_typ [STACK_DEPTH];

    logic               push_c;
    logic [DEPTH_W-1:0] pop_idx;
    logic               top_rlo;
    logic               top_fc;
    logic [1:0]         top_typ;
    logic               fc_eff;
    logic               top_fc_eff;
    logic               pop_comb;

    assign pop_idx = depth_q - ONE_DEPTH;
    assign top_rlo = stk_rlo[pop_idx];
    assign top_fc  = stk_fc[pop_idx];
    assign top_typ = stk_typ[pop_idx];

`ifdef RLO_LU_FC_EN
    assign fc_eff     = fc_q;
    assign top_fc_eff = top_fc;
    assign LU_FC      = fc_q;
`else
    // FC is architecturally forced to 1; the stored bits are kept but never matter
    assign fc_eff     = fc_q | 1'b1;
    assign top_fc_eff = top_fc | 1'b1;
    assign LU_FC      = fc_q | 1'b1;
`endif

    assign LU_Resoult   = res_q;
    assign LU_Valid     = valid_q;
    assign LU_Depth     = depth_q;
    assign LU_Overflow  = ovf_q;
    assign LU_Underflow = unf_q;

    // Combine the popped entry with the current RLO according to its stored type
    always_comb begin
        pop_comb = RLO;
        case (top_typ)
            TYP_AND: pop_comb = top_rlo & RLO;
            TYP_OR:  pop_comb = top_rlo | RLO;
            TYP_XOR: pop_comb = top_rlo ^ RLO;
            default: pop_comb = RLO;
        endcase
        if (!top_fc_eff) begin
            pop_comb = RLO;
        end
    end

    // Next-state decode of the current opcode
    always_comb begin
        res_d   = res_q;
        valid_d = 1'b0;
        depth_d = depth_q;
        fc_d    = fc_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_c  = 1'b0;
        if (LU_EN) begin
            case (LU_OPCode)
                OP_NOP: begin
                end
                OP_A, OP_AN: begin
                    res_d   = fc_eff ? (RLO & (LU_Operand ^ (LU_OPCode == OP_AN)))
                                     : (LU_Operand ^ (LU_OPCode == OP_AN));
                    fc_d    = 1'b1;
                    valid_d = 1'b1;
                end
                OP_O, OP_ON: begin
                    res_d   = fc_eff ? (RLO | (LU_Operand ^ (LU_OPCode == OP_ON)))
                                     : (LU_Operand ^ (LU_OPCode == OP_ON));
                    fc_d    = 1'b1;
                    valid_d = 1'b1;
                end
                OP_X, OP_XN: begin
                    res_d   = fc_eff ? (RLO ^ (LU_Operand ^ (LU_OPCode == OP_XN)))
                                     : (LU_Operand ^ (LU_OPCode == OP_XN));
                    fc_d    = 1'b1;
                    valid_d = 1'b1;
                end
                OP_NOT: begin
                    res_d   = ~RLO;
                    valid_d = 1'b1;
                end
                OP_APSH, OP_OPSH, OP_XPSH: begin
                    if (depth_q < MAX_DEPTH) begin
                        push_c  = 1'b1;
                        depth_d = depth_q + ONE_DEPTH;
                        fc_d    = 1'b0;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                OP_POP: begin
                    if (depth_q != '0) begin
                        depth_d = pop_idx;
                        res_d   = pop_comb;
                        fc_d    = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                OP_CLR: begin
                    depth_d = '0;
                    fc_d    = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // State register with asynchronous active-high reset
    always_ff @(posedge CLK or posedge CPU_Reset) begin
        if (CPU_Reset) begin
            res_q   <= 1'b0;
            valid_q <= 1'b0;
            depth_q <= '0;
            fc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
            depth_q <= depth_d;
            fc_q    <= fc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack write on a successful push
    always_ff @(posedge CLK) begin
        if (push_c) begin
            stk_rlo[depth_q] <= RLO;
            stk_fc[depth_q]  <= fc_q;
            stk_typ[depth_q] <= LU_OPCode[1:0];
        end
    end

endmodule

// File: doc/rlo_logic_unit.md
Name: rlo_logic_unit

Overview:
Bit-logic unit directly upstream of the RLO register. It combines the current RLO with a single-bit operand using AND/OR/XOR instruction-list semantics, including first-check (FC) loading and a parenthesis nesting stack. Its registered result drives the RLO register's logic-unit-result input, which the controller selects with RLO opcode 3'b011.

Parameters:
STACK_DEPTH, 7, maximum nesting levels; must be ≤ 2**DEPTH_W − 1
DEPTH_W, 3, width of the depth counter / LU_Depth port

Ports:
CLK  in  1  clock, rising edge
CPU_Reset  in  1  asynchronous, active-high reset
LU_EN  in  1  execute LU_OPCode this cycle
LU_OPCode  in  4  operation (see Behaviour)
LU_Operand  in  1  bit operand (from RAM, registers, inputs)
RLO  in  1  current RLO from the RLO register
LU_Resoult  out  1  registered logic result
LU_Valid  out  1  one-cycle pulse: LU_Resoult updated
LU_Depth  out  DEPTH_W  current nesting depth
LU_FC  out  1  first-check flag (0 = next logic op loads)
LU_Overflow  out  1  sticky: push attempted at full stack
LU_Underflow  out  1  sticky: pop attempted at empty stack

Behaviour:
- Reset (async): LU_Resoult=0, LU_Valid=0, LU_Depth=0, LU_FC=0, LU_Overflow=0, LU_Underflow=0; stack contents are don't-care.
- Opcodes execute only when LU_EN=1. With LU_EN=0, all state holds and LU_Valid=0.
- One opcode per cycle. Inputs are sampled on the rising edge. Results appear the following cycle (latency 1).
- LU_Valid defaults to 0 each cycle.
- Opcode 0000 NOP: no state change.
- Logic ops, with op = LU_Operand, or ~LU_Operand for the N variants:
  - 0001 A, 0010 AN: result = FC ? RLO&op : op
  - 0011 O, 0100 ON: result = FC ? RLO|op : op
  - 0101 X, 0110 XN: result = FC ? RLO^op : op
  - Each logic op: LU_Resoult <= result, LU_FC <= 1, LU_Valid <= 1.
- 0111 NOT: LU_Resoult <= ~RLO, LU_Valid <= 1, FC unchanged.
- Push (1000 A(, 1001 O(, 1010 X():
  - If depth < STACK_DEPTH: push {RLO, FC, type}; depth+1; FC <= 0; LU_Valid=0.
  - If depth == STACK_DEPTH: LU_Overflow <= 1; stack, depth and FC unchanged.
- 1011 Pop ")":
  - If depth > 0: pop entry {sR, sFC, type}; depth−1. Result = sFC ? (sR type RLO) : RLO. LU_Resoult <= result, LU_FC <= 1, LU_Valid <= 1.
  - If depth == 0: LU_Underflow <= 1; no other change.
- 1100 CLR: depth <= 0, FC <= 0, both sticky flags cleared, LU_Resoult holds.
- 1101–1111: treated as NOP.
- LU_Resoult holds its value between valid ops.
- RLO input is taken as given. Hazard-free sequencing (RLO register loaded before the next op) is the controller's responsibility.
- CPU_Reset mid-nesting discards all stack entries immediately.

Optional Feature:
RLO_LU_FC_EN
- Defined: first-check semantics as above.
- Undefined: FC is forced to 1. Logic ops always combine with RLO. Pop always combines with the stacked RLO. LU_FC output is tied to 1. Push still stores the FC bit, which is ignored on pop.

Test Plan:
1. Reset mid-op: depth=2, LU_Overflow=1, assert CPU_Reset → all outputs 0 immediately, without waiting for a clock edge.
2. FC load: after reset, EN with A, Operand=1, RLO=0 → next cycle LU_Resoult=1, LU_Valid=1 for one cycle, LU_FC=1. Then AN, Operand=1, RLO=1 → LU_Resoult=0.
3. Nesting: RLO=1, FC=1. Push O( → depth=1, FC=0, LU_Valid=0. A Operand=0 → LU_Resoult=0. Pop with RLO=0 → LU_Resoult=1 (1|0), depth=0.
4. Overflow: 7 pushes → depth=7. 8th push → LU_Overflow=1, depth stays 7. CLR → depth=0, LU_Overflow=0.
5. Underflow: pop at depth=0 → LU_Underflow=1, LU_Valid=0, LU_Resoult unchanged.
6. Gating and XOR: LU_EN=0 with opcode X → no change. NOT with RLO=0 → LU_Resoult=1. XN with FC=1, RLO=1, Operand=0 → LU_Resoult=0.
